othello_score_ctrl: RTL and testbench
=====================================

# othello_score_ctrl

Sequencing controller wrapped around the board piece counter. After every committed move or pass it waits for the counter's registered black/red counts to settle, latches the scores, and hands the turn to the other player. It also detects game-over and resolves the winner. It sits between the move-execution logic, which pulses `move_done`/`pass`, and the display/VGA score path.

## Interface
- `SETTLE`, default 2: cycles from the commit edge until `cntB`/`cntR` reflect the new board; legal range 1–7. Covers the board register plus the counter's one register stage.
- `BOARD_CELLS`, default 64: total cells; the board is full when the score sum equals this value.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `new_game` in 1: one-cycle pulse; restarts the game from any state.
- `move_done` in 1: one-cycle pulse; board registers commit a move at this edge.
- `pass` in 1: one-cycle pulse; the player to move has no legal move.
- `cntB` in 8: black piece count from the counter.
- `cntR` in 8: red piece count from the counter.
- `turn` out 1: player to move; 0 = black, 1 = red.
- `busy` out 1: high while a settle/evaluate sequence is in progress.
- `score_valid` out 1: one-cycle pulse when the scores are updated.
- `scoreB` out 8: latched black score.
- `scoreR` out 8: latched red score.
- `game_over` out 1: sticky until `new_game`.
- `winner` out 2: 00 none, 01 black, 10 red, 11 tie.

## Operation
- **Reset values:** `turn`=0, `busy`=0, `score_valid`=0, `scoreB`=0, `scoreR`=0, `game_over`=0, `winner`=00. Internal state: state=IDLE, settle counter=0, init flag=0, pass_cnt=0.
- **States:** IDLE, SETTLE, EVAL, OVER.
- **IDLE:**
  - `move_done` → SETTLE. Loads the settle counter with `SETTLE` and clears pass_cnt.
  - `pass` → toggles `turn`; see Configuration for pass counting.
  - If `move_done` and `pass` arrive together, `move_done` wins and `pass` is dropped.
- **SETTLE:** the counter decrements each cycle; reaching 0 moves to EVAL. `busy`=1.
- **EVAL** (one cycle):
  - Latch `scoreB`=`cntB` and `scoreR`=`cntR`; pulse `score_valid`.
  - If the init flag is 0, toggle `turn`. If the init flag is 1, clear it and leave `turn`=0.
  - Game over when any of these hold:
    - `cntB`+`cntR` (9-bit sum) == `BOARD_CELLS`
    - `cntB`==0
    - `cntR`==0
  - Game over → OVER. Otherwise → IDLE.
  - Game-over checks are skipped while the init flag is set.
- **OVER:**
  - `game_over`=1.
  - `winner` is set on entry: `scoreB`>`scoreR` gives 01, < gives 10, == gives 11. The comparison is unsigned.
  - `move_done` and `pass` are ignored.
- **`new_game`:**
  - Highest priority in every state.
  - Clears `game_over`, `winner`, and pass_cnt; sets `turn`=0 and init=1.
  - Enters SETTLE with the counter loaded with `SETTLE`, so the opening 2/2 scores are published without a turn change.
- **Busy rules:** `move_done`/`pass` while `busy`=1 are dropped silently. The source must wait for `busy`=0.
- **Reset mid-sequence:** asynchronous return to reset values. A pending evaluation is discarded and `score_valid` does not fire.

## Timing
- Let `move_done` (or `new_game`) be sampled at edge t.
  - `busy` goes high after edge t.
  - The settle counter reaches 0 at edge t+SETTLE.
  - EVAL occupies the cycle after that edge.
  - `cntB`/`cntR` are sampled and the outputs (`scoreB`, `scoreR`, `turn`, `game_over`, `winner`) update at edge t+SETTLE+1.
  - `score_valid` is high for the single cycle following edge t+SETTLE+1.
  - `busy` goes low after edge t+SETTLE+1.
- Next accepted `move_done`: edge t+SETTLE+2 at the earliest.
- `pass` in IDLE: `turn` toggles at the sampling edge. No `busy` assertion and no `score_valid`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `OTHELLO_PASS_DETECT_EN` defined:
  - Each accepted `pass` increments a 2-bit pass_cnt; `move_done` and `new_game` clear it.
  - When pass_cnt reaches 2 (two consecutive passes), the next edge moves to OVER with the winner resolved from the currently latched `scoreB`/`scoreR`.
  - `turn` still toggles on the second pass.
- Undefined:
  - pass_cnt logic is absent; `pass` only toggles `turn`.
  - Game over comes only from board-full or a zero count.

## Test plan
- Reset, then `new_game` with `cntB`=2, `cntR`=2, `SETTLE`=2 → `score_valid` one cycle after edge t+3; `scoreB`=`scoreR`=2; `turn`=0; `game_over`=0.
- `move_done` with `cntB`=4, `cntR`=1 → at edge t+3, `scoreB`=4, `scoreR`=1, `turn` 0→1, `busy` high for 3 cycles; a second `move_done` at t+1 is ignored.
- `move_done` with `cntB`=40, `cntR`=24 → `game_over`=1, `winner`=01; later `move_done`/`pass` are ignored; `new_game` clears to `winner`=00.
- `move_done` with `cntB`=0, `cntR`=10 → `game_over`=1, `winner`=10. Separately, 32/32 on a full board → `winner`=11.
- With `OTHELLO_PASS_DETECT_EN` and scores 20/18: `pass`, `pass` → `turn` toggles twice; `game_over`=1, `winner`=01. Repeating with a `move_done` between the passes → no game over.
- `RST` asserted during SETTLE → outputs return to reset values immediately and no `score_valid` pulse occurs.

Source files
------------

// File: rtl/othello_score_ctrl_if.sv
// othello_score_ctrl_if: move-logic <-> score controller bus; master drives the
// move pulses and counter values, slave (the controller) drives turn/score/status.
interface othello_score_ctrl_if;
  logic new_game;
  logic move_done;
  logic pass;
  logic [7:0] cntB;
  logic [7:0] cntR;
  logic turn;
  logic busy;
  logic score_valid;
  logic [7:0] scoreB;
  logic [7:0] scoreR;
  logic game_over;
  logic [1:0] winner;
  modport master (
    output new_game, move_done, pass, cntB, cntR,
    input  turn, busy, score_valid, scoreB, scoreR, game_over, winner
  );
  modport slave (
    input  new_game, move_done, pass, cntB, cntR,
    output turn, busy, score_valid, scoreB, scoreR, game_over, winner
  );
endinterface

// File: rtl/othello_score_ctrl.sv
// othello_score_ctrl: waits for piece counts to settle after each move, latches
// scores, hands over the turn and resolves game-over / winner.
//   clk, RST (async active-low); bus (slave): new_game/move_done/pass pulses and
//   cntB/cntR in; turn, busy, score_valid, scoreB, scoreR, game_over, winner out.
//   Optional OTHELLO_PASS_DETECT_EN: two consecutive passes end the game.
module othello_score_ctrl #(
  parameter int SETTLE      = 2,
  parameter int BOARD_CELLS = 64
) (
  input logic clk,
  input logic RST,
  othello_score_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EVAL, S_OVER} state_t;
  state_t state, nState;
  logic [2:0] cnt, nCnt;
  logic initFlag, nInit, nTurn, nValid, nOver, nBusy;
  logic [7:0] nScoreB, nScoreR;
  logic [1:0] nWinner;
  logic [8:0] sum;
  logic passOver;
`ifdef OTHELLO_PASS_DETECT_EN
  logic [1:0] passCnt, nPassCnt;
  assign passOver = passCnt == 2'd2;
`else
  assign passOver = 1'b0;
`endif

  function automatic logic [1:0] resolve(input logic [7:0] b, input logic [7:0] r);
    return b > r ? 2'b01 : b < r ? 2'b10 : 2'b11;
  endfunction

  assign sum = {1'b0, bus.cntB} + {1'b0, bus.cntR};

  always_comb begin
    nState  = state;
    nCnt    = cnt;
    nInit   = initFlag;
    nTurn   = bus.turn;
    nScoreB = bus.scoreB;
    nScoreR = bus.scoreR;
    nValid  = 1'b0;
    nOver   = bus.game_over;
    nWinner = bus.winner;
`ifdef OTHELLO_PASS_DETECT_EN
    nPassCnt = passCnt;
`endif
    if (bus.new_game) begin
      nState  = S_SETTLE;
      nCnt    = 3'(SETTLE);
      nInit   = 1'b1;
      nTurn   = 1'b0;
      nOver   = 1'b0;
      nWinner = 2'b00;
`ifdef OTHELLO_PASS_DETECT_EN
      nPassCnt = 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE:
          if (passOver) begin
            nState  = S_OVER;
            nOver   = 1'b1;
            nWinner = resolve(bus.scoreB, bus.scoreR);
          end else if (bus.move_done) begin
            nState = S_SETTLE;
            nCnt   = 3'(SETTLE);
`ifdef OTHELLO_PASS_DETECT_EN
            nPassCnt = 2'd0;
`endif
          end else if (bus.pass) begin
            nTurn = ~bus.turn;
`ifdef OTHELLO_PASS_DETECT_EN
            nPassCnt = passCnt + 2'd1;
`endif
          end
        S_SETTLE: begin
          nCnt   = cnt - 3'd1;
          nState = cnt == 3'd1 ? S_EVAL : S_SETTLE;
        end
        S_EVAL: begin
          nScoreB = bus.cntB;
          nScoreR = bus.cntR;
          nValid  = 1'b1;
          nTurn   = initFlag ? 1'b0 : ~bus.turn;
          nInit   = 1'b0;
          // the opening evaluation only publishes the 2/2 start position
          if (!initFlag && (sum == 9'(BOARD_CELLS) || bus.cntB == 8'd0 || bus.cntR == 8'd0)) begin
            nState  = S_OVER;
            nOver   = 1'b1;
            nWinner = resolve(bus.cntB, bus.cntR);
          end else begin
            nState = S_IDLE;
          end
        end
        default: ;
      endcase
    end
    nBusy = nState == S_SETTLE || nState == S_EVAL;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state           <= S_IDLE;
      cnt             <= 3'd0;
      initFlag        <= 1'b0;
      bus.turn        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.score_valid <= 1'b0;
      bus.scoreB      <= 8'd0;
      bus.scoreR      <= 8'd0;
      bus.game_over   <= 1'b0;
      bus.winner      <= 2'b00;
`ifdef OTHELLO_PASS_DETECT_EN
      passCnt         <= 2'd0;
`endif
    end else begin
      state           <= nState;
      cnt             <= nCnt;
      initFlag        <= nInit;
      bus.turn        <= nTurn;
      bus.busy        <= nBusy;
      bus.score_valid <= nValid;
      bus.scoreB      <= nScoreB;
      bus.scoreR      <= nScoreR;
      bus.game_over   <= nOver;
      bus.winner      <= nWinner;
`ifdef OTHELLO_PASS_DETECT_EN
      passCnt         <= nPassCnt;
`endif
    end
  end
endmodule

// File: tb/tb_othello_score_ctrl.sv
// tb_othello_score_ctrl: directed checks of settle timing, turn handover,
// game-over resolution, pass handling and mid-sequence reset.
module tb_othello_score_ctrl;
  logic clk = 1'b0;
  logic RST = 1'b0;
  int passed = 0;
  int total = 0;

  othello_score_ctrl_if bus();

  othello_score_ctrl #(.SETTLE(2), .BOARD_CELLS(64)) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic pulseMove();
    @(negedge clk); bus.move_done = 1'b1;
    @(negedge clk); bus.move_done = 1'b0;
  endtask

  task automatic pulsePass();
    @(negedge clk); bus.pass = 1'b1;
    @(negedge clk); bus.pass = 1'b0;
  endtask

  task automatic newGame(input logic [7:0] b, input logic [7:0] r);
    bus.cntB = b; bus.cntR = r;
    @(negedge clk); bus.new_game = 1'b1;
    @(negedge clk); bus.new_game = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic doMove(input logic [7:0] b, input logic [7:0] r);
    bus.cntB = b; bus.cntR = r;
    pulseMove();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.turn !== 1'b0) $display("FAIL rst_turn got %0d exp 0", bus.turn); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %0d exp 0", bus.busy); else passed++;
    total++; if (bus.score_valid !== 1'b0) $display("FAIL rst_valid got %0d exp 0", bus.score_valid); else passed++;
    total++; if ({bus.scoreB, bus.scoreR} !== 16'd0) $display("FAIL rst_scores got %0h exp 0", {bus.scoreB, bus.scoreR}); else passed++;
    total++; if ({bus.game_over, bus.winner} !== 3'd0) $display("FAIL rst_over got %0h exp 0", {bus.game_over, bus.winner}); else passed++;
    RST = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_new_game();
    bus.cntB = 8'd2; bus.cntR = 8'd2;
    @(negedge clk); bus.new_game = 1'b1;
    @(negedge clk); bus.new_game = 1'b0;
    total++; if (bus.busy !== 1'b1) $display("FAIL ng_busy0 got %0d exp 1", bus.busy); else passed++;
    @(negedge clk);
    @(negedge clk);
    total++; if ({bus.busy, bus.score_valid} !== 2'b10) $display("FAIL ng_pre_valid got %b exp 10", {bus.busy, bus.score_valid}); else passed++;
    @(negedge clk);
    total++; if (bus.score_valid !== 1'b1) $display("FAIL ng_valid got %0d exp 1", bus.score_valid); else passed++;
    total++; if ({bus.scoreB, bus.scoreR} !== {8'd2, 8'd2}) $display("FAIL ng_scores got %0h exp 0202", {bus.scoreB, bus.scoreR}); else passed++;
    total++; if ({bus.turn, bus.game_over, bus.busy} !== 3'b000) $display("FAIL ng_state got %b exp 000", {bus.turn, bus.game_over, bus.busy}); else passed++;
    @(negedge clk);
    total++; if (bus.score_valid !== 1'b0) $display("FAIL ng_valid_pulse got %0d exp 0", bus.score_valid); else passed++;
  endtask

  task automatic test_move();
    int busyCycles = 0;
    bus.cntB = 8'd4; bus.cntR = 8'd1;
    @(negedge clk); bus.move_done = 1'b1;
    @(negedge clk);
    busyCycles += int'(bus.busy);
    @(negedge clk); bus.move_done = 1'b0;
    busyCycles += int'(bus.busy);
    @(negedge clk);
    busyCycles += int'(bus.busy);
    total++; if (bus.turn !== 1'b0) $display("FAIL mv_turn_early got %0d exp 0", bus.turn); else passed++;
    @(negedge clk);
    busyCycles += int'(bus.busy);
    total++; if (bus.score_valid !== 1'b1) $display("FAIL mv_valid got %0d exp 1", bus.score_valid); else passed++;
    total++; if ({bus.scoreB, bus.scoreR} !== {8'd4, 8'd1}) $display("FAIL mv_scores got %0h exp 0401", {bus.scoreB, bus.scoreR}); else passed++;
    total++; if (bus.turn !== 1'b1) $display("FAIL mv_turn got %0d exp 1", bus.turn); else passed++;
    total++; if (busyCycles !== 3) $display("FAIL mv_busy_cycles got %0d exp 3", busyCycles); else passed++;
    repeat (2) @(negedge clk);
    total++; if ({bus.busy, bus.score_valid, bus.game_over} !== 3'b000) $display("FAIL mv_no_requeue got %b exp 000", {bus.busy, bus.score_valid, bus.game_over}); else passed++;
  endtask

  task automatic test_pass();
    bus.cntB = 8'd20; bus.cntR = 8'd18;
    @(negedge clk); bus.move_done = 1'b1; bus.pass = 1'b1;
    @(negedge clk); bus.move_done = 1'b0;
    total++; if ({bus.turn, bus.busy} !== 2'b11) $display("FAIL ps_collide got %b exp 11", {bus.turn, bus.busy}); else passed++;
    @(negedge clk); bus.pass = 1'b0;
    total++; if (bus.turn !== 1'b1) $display("FAIL ps_busy_drop got %0d exp 1", bus.turn); else passed++;
    repeat (2) @(negedge clk);
    total++; if ({bus.turn, bus.scoreB, bus.scoreR} !== {1'b0, 8'd20, 8'd18}) $display("FAIL ps_move got %0h exp 01412", {bus.turn, bus.scoreB, bus.scoreR}); else passed++;
    pulsePass();
    total++; if ({bus.turn, bus.busy, bus.score_valid} !== 3'b100) $display("FAIL ps_first got %b exp 100", {bus.turn, bus.busy, bus.score_valid}); else passed++;
    pulsePass();
    total++; if (bus.turn !== 1'b0) $display("FAIL ps_second got %0d exp 0", bus.turn); else passed++;
    @(negedge clk);
`ifdef OTHELLO_PASS_DETECT_EN
    total++; if ({bus.game_over, bus.winner} !== 3'b101) $display("FAIL ps_over got %b exp 101", {bus.game_over, bus.winner}); else passed++;
    newGame(8'd2, 8'd2);
    doMove(8'd20, 8'd18);
    pulsePass();
    doMove(8'd20, 8'd18);
    pulsePass();
    repeat (2) @(negedge clk);
    total++; if ({bus.game_over, bus.winner} !== 3'b000) $display("FAIL ps_split got %b exp 000", {bus.game_over, bus.winner}); else passed++;
`else
    total++; if ({bus.game_over, bus.winner} !== 3'b000) $display("FAIL ps_no_over got %b exp 000", {bus.game_over, bus.winner}); else passed++;
`endif
  endtask

  task automatic test_game_over();
    newGame(8'd2, 8'd2);
    doMove(8'd40, 8'd24);
    total++; if ({bus.game_over, bus.winner, bus.score_valid} !== 4'b1011) $display("FAIL go_black got %b exp 1011", {bus.game_over, bus.winner, bus.score_valid}); else passed++;
    total++; if (bus.turn !== 1'b1) $display("FAIL go_turn got %0d exp 1", bus.turn); else passed++;
    pulseMove();
    total++; if (bus.busy !== 1'b0) $display("FAIL go_move_ignored got %0d exp 0", bus.busy); else passed++;
    pulsePass();
    total++; if ({bus.turn, bus.score_valid, bus.game_over} !== 3'b101) $display("FAIL go_pass_ignored got %b exp 101", {bus.turn, bus.score_valid, bus.game_over}); else passed++;
    @(negedge clk); bus.new_game = 1'b1;
    @(negedge clk); bus.new_game = 1'b0;
    total++; if ({bus.game_over, bus.winner, bus.turn, bus.busy} !== 5'b00001) $display("FAIL go_clear got %b exp 00001", {bus.game_over, bus.winner, bus.turn, bus.busy}); else passed++;
    repeat (3) @(negedge clk);
    doMove(8'd0, 8'd10);
    total++; if ({bus.game_over, bus.winner} !== 3'b110) $display("FAIL go_red got %b exp 110", {bus.game_over, bus.winner}); else passed++;
    newGame(8'd2, 8'd2);
    doMove(8'd5, 8'd0);
    total++; if ({bus.game_over, bus.winner} !== 3'b101) $display("FAIL go_red_zero got %b exp 101", {bus.game_over, bus.winner}); else passed++;
    newGame(8'd2, 8'd2);
    doMove(8'd33, 8'd30);
    total++; if ({bus.game_over, bus.winner} !== 3'b000) $display("FAIL go_sum63 got %b exp 000", {bus.game_over, bus.winner}); else passed++;
    doMove(8'd32, 8'd32);
    total++; if ({bus.game_over, bus.winner, bus.scoreB} !== {3'b111, 8'd32}) $display("FAIL go_tie got %0h exp 720", {bus.game_over, bus.winner, bus.scoreB}); else passed++;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    newGame(8'd2, 8'd2);
    doMove(8'd4, 8'd1);
    bus.cntB = 8'd9; bus.cntR = 8'd9;
    pulseMove();
    #2 RST = 1'b0;
    #1;
    total++; if ({bus.turn, bus.busy, bus.score_valid} !== 3'b000) $display("FAIL rm_flags got %b exp 000", {bus.turn, bus.busy, bus.score_valid}); else passed++;
    total++; if ({bus.scoreB, bus.scoreR} !== 16'd0) $display("FAIL rm_scores got %0h exp 0", {bus.scoreB, bus.scoreR}); else passed++;
    @(negedge clk); RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen += int'(bus.score_valid | bus.busy);
    end
    total++; if (seen !== 0) $display("FAIL rm_no_valid got %0d exp 0", seen); else passed++;
  endtask

  initial begin
    bus.new_game = 1'b0; bus.move_done = 1'b0; bus.pass = 1'b0;
    bus.cntB = 8'd0; bus.cntR = 8'd0;
    test_reset();
    test_new_game();
    test_move();
    test_pass();
    test_game_over();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
